iterative_divider36_31: RTL

ITERATIVE_DIVIDER36_31 -- requirements
Module: iterative_divider36_31

---
 rtl/iterative_divider36_31.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/iterative_divider36_31.sv
// Restoring 36/31-bit unsigned divider, one quotient bit per cycle, valid/ready handshakes.
// Optional macro DIV_ZERO_FAST_EN: zero divisor completes the cycle after accept and flags div_by_zero.
module iterative_divider36_31 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [35:0] dividend,
    input  logic [30:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] quotient,
    output logic [30:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [35:0] shift_q;
    logic [30:0] divisor_q;
    logic [30:0] rem_q;
    logic [5:0]  count;

    logic        accept;
    logic        zero_div;
    logic [31:0] trial;
    logic [31:0] diff;
    logic        q_bit;
    logic [30:0] rem_next;

    assign accept = in_valid & in_ready;

`ifdef DIV_ZERO_FAST_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_comb begin
        trial    = {rem_q, shift_q[35]};
        diff     = trial - {1'b0, divisor_q};
        q_bit    = (trial >= {1'b0, divisor_q});
        // After a successful subtraction the result is below the divisor, so 31 bits suffice.
        rem_next = q_bit ? diff[30:0] : trial[30:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    next_state = zero_div ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_q   <= dividend;
                        divisor_q <= divisor;
                        rem_q     <= '0;
                        count     <= 6'd35;
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend[30:0];
                        end
                    end
                end
                BUSY: begin
                    shift_q <= {shift_q[34:0], q_bit};
                    rem_q   <= rem_next;
                    if (count != '0) begin
                        count <= count - 6'd1;
                    end else begin
                        quotient  <= {shift_q[34:0], q_bit};
                        remainder <= rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_FAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            div_by_zero <= 1'b0;
        end else if (state == IDLE && accept) begin
            if (zero_div) begin
                div_by_zero <= 1'b1;
            end
        end else if (state == BUSY && count == '0) begin
            div_by_zero <= 1'b0;
        end
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
